// File: rtl/isr_sequencer.sv
// Interrupt entry/exit sequencer: saves the resume PC, vectors to the ISR, restores it on reti.
// Define ISR_NESTING_EN for a stackDepth-entry return stack; otherwise a single saved PC.
module isr_sequencer #(
    parameter int pcWidth    = 16,
    parameter int stackDepth = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            intPending,
    input  logic [pcWidth-1:0]              intAddr,
    input  logic                            intEnable,
    input  logic                            instrDone,
    input  logic                            reti,
    input  logic [pcWidth-1:0]              curPC,
    output logic                            pcLoad,
    output logic [pcWidth-1:0]              pcOut,
    output logic                            stall,
    output logic                            pendClr,
    output logic                            intDisable,
    output logic [$clog2(stackDepth+1)-1:0] nestLevel,
    output logic                            retiErr
);

    localparam int spW = $clog2(stackDepth + 1);
`ifdef ISR_NESTING_EN
    localparam int depth = stackDepth;
`else
    localparam int depth = 1;
`endif
    localparam logic [spW-1:0] depthSp = spW'(depth);

    typedef enum logic [1:0] {RUN, VECTOR, RESTORE} seqStateT;

    seqStateT             state, stateNext;
    logic [spW-1:0]       sp, spNext, spDec;
    logic [pcWidth-1:0]   stack [depth];
    logic [pcWidth-1:0]   popVal;
    logic [pcWidth-1:0]   pcOutNext;
    logic                 pcLoadNext, pendClrNext, stallNext, intDisableNext, retiErrNext;
    logic                 pushEn;

    assign spDec     = sp - spW'(1);
    assign nestLevel = sp;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        stateNext   = state;
        spNext      = sp;
        pushEn      = 1'b0;
        pcLoadNext  = 1'b0;
        pcOutNext   = pcOut;
        pendClrNext = 1'b0;
        stallNext   = 1'b0;
        retiErrNext = retiErr;
        popVal      = '0;

        for (int i = 0; i < depth; i++) begin
            if (spDec == spW'(i)) popVal = stack[i];
        end

        case (state)
            RUN: begin
                if (instrDone) begin
                    // reti outranks a simultaneous interrupt; the interrupt waits for the next boundary.
                    if (reti) begin
                        if (sp != '0) begin
                            stateNext  = RESTORE;
                            spNext     = spDec;
                            pcLoadNext = 1'b1;
                            stallNext  = 1'b1;
                            pcOutNext  = popVal;
                        end else begin
                            retiErrNext = 1'b1;
                        end
                    end else if (intPending && intEnable && (sp < depthSp)) begin
                        stateNext   = VECTOR;
                        spNext      = sp + spW'(1);
                        pushEn      = 1'b1;
                        pcLoadNext  = 1'b1;
                        pcOutNext   = intAddr;
                        pendClrNext = 1'b1;
                        stallNext   = 1'b1;
                    end
                end
            end
            default: stateNext = RUN;
        endcase

        intDisableNext = ~intEnable | (stateNext != RUN) | (spNext == depthSp);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            sp         <= '0;
            pcLoad     <= 1'b0;
            pcOut      <= '0;
            pendClr    <= 1'b0;
            stall      <= 1'b0;
            intDisable <= 1'b1;
            retiErr    <= 1'b0;
        end else begin
            state      <= stateNext;
            sp         <= spNext;
            pcLoad     <= pcLoadNext;
            pcOut      <= pcOutNext;
            pendClr    <= pendClrNext;
            stall      <= stallNext;
            intDisable <= intDisableNext;
            retiErr    <= retiErrNext;
        end
    end

    // NOTE: stack storage has no reset; sp going to 0 on reset is what discards its contents.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            for (int i = 0; i < depth; i++) begin
                if (sp == spW'(i)) stack[i] <= curPC;
            end
        end
    end

endmodule

// File: tb/tb_isr_sequencer.sv
// Self-checking bench for isr_sequencer: scoreboard of expected PC loads plus direct state checks.
// Follows the ISR_NESTING_EN setting of the build for the expected stack depth.
module tb_isr_sequencer;

`ifdef ISR_NESTING_EN
    localparam int depth = 4;
`else
    localparam int depth = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        intPending;
    logic [15:0] intAddr;
    logic        intEnable;
    logic        instrDone;
    logic        reti;
    logic [15:0] curPC;
    logic        pcLoad;
    logic [15:0] pcOut;
    logic        stall;
    logic        pendClr;
    logic        intDisable;
    logic [2:0]  nestLevel;
    logic        retiErr;

    typedef struct packed {
        logic [15:0] pc;
        logic        clr;
    } loadExpT;

    loadExpT sbQ [$];
    int      compared   = 0;
    int      mismatched = 0;
    int      pendClrSeen = 0;

    isr_sequencer #(.pcWidth(16), .stackDepth(4)) dut (
        .clk(clk), .rst(rst), .intPending(intPending), .intAddr(intAddr),
        .intEnable(intEnable), .instrDone(instrDone), .reti(reti), .curPC(curPC),
        .pcLoad(pcLoad), .pcOut(pcOut), .stall(stall), .pendClr(pendClr),
        .intDisable(intDisable), .nestLevel(nestLevel), .retiErr(retiErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Every PC load must match the oldest expectation in the scoreboard.
    always @(negedge clk) begin
        if (pendClr) pendClrSeen++;
        if (pcLoad) begin
            if (sbQ.size() == 0) begin
                check("unexpected_pcLoad", {16'h0, pcOut}, 32'hFFFF_FFFF);
            end else begin
                loadExpT e;
                e = sbQ.pop_front();
                check("pcOut", {16'h0, pcOut}, {16'h0, e.pc});
                check("pendClr", {31'h0, pendClr}, {31'h0, e.clr});
                check("stall_with_load", {31'h0, stall}, 32'h1);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic boundary(input logic r, input logic pend, input logic [15:0] addr,
                            input logic [15:0] pc);
        instrDone  = 1'b1;
        reti       = r;
        intPending = pend;
        intAddr    = addr;
        curPC      = pc;
        nextCycle();
        instrDone = 1'b0;
        reti      = 1'b0;
    endtask

    task automatic expectLoad(input logic [15:0] pc, input logic clr);
        loadExpT e;
        e.pc  = pc;
        e.clr = clr;
        sbQ.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pcBefore;
        logic [15:0] savedPc [depth];

        rst = 1'b1; intPending = 1'b0; intAddr = '0; intEnable = 1'b1;
        instrDone = 1'b0; reti = 1'b0; curPC = '0;

        // Reset values, then intDisable drops one cycle after release.
        repeat (2) nextCycle();
        @(negedge clk);
        check("rst_pcLoad", {31'h0, pcLoad}, 0);
        check("rst_pcOut", {16'h0, pcOut}, 0);
        check("rst_pendClr", {31'h0, pendClr}, 0);
        check("rst_stall", {31'h0, stall}, 0);
        check("rst_intDisable", {31'h0, intDisable}, 1);
        check("rst_nestLevel", {29'h0, nestLevel}, 0);
        check("rst_retiErr", {31'h0, retiErr}, 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        check("intDisable_held", {31'h0, intDisable}, 1);
        nextCycle();
        @(negedge clk);
        check("intDisable_release", {31'h0, intDisable}, 0);

        // Entry; intAddr changing after the boundary must not alter the vector.
        expectLoad(16'h0040, 1'b1);
        boundary(1'b0, 1'b1, 16'h0040, 16'h1234);
        intPending = 1'b0;
        intAddr    = 16'hFFFF;
        @(negedge clk);
        check("entry_nest_T1", {29'h0, nestLevel}, 1);
        check("entry_intDisable_T1", {31'h0, intDisable}, 1);
        nextCycle();
        @(negedge clk);
        check("entry_pcLoad_T2", {31'h0, pcLoad}, 0);
        check("entry_stall_T2", {31'h0, stall}, 0);
        check("entry_nest_T2", {29'h0, nestLevel}, 1);
        check("entry_intDisable_T2", {31'h0, intDisable}, (depth == 1) ? 1 : 0);

        // Exit restores the saved PC.
        expectLoad(16'h1234, 1'b0);
        boundary(1'b1, 1'b0, 16'h0000, 16'h5555);
        @(negedge clk);
        check("exit_nest_T1", {29'h0, nestLevel}, 0);
        check("exit_intDisable_T1", {31'h0, intDisable}, 1);
        nextCycle();
        @(negedge clk);
        check("exit_intDisable_T2", {31'h0, intDisable}, 0);
        check("exit_sb_empty", sbQ.size(), 0);

        // Re-enter, then a reti boundary during VECTOR must be ignored.
        expectLoad(16'h0040, 1'b1);
        boundary(1'b0, 1'b1, 16'h0040, 16'h1234);
        intPending = 1'b0;
        instrDone  = 1'b1;
        reti       = 1'b1;
        nextCycle();
        instrDone = 1'b0;
        reti      = 1'b0;
        @(negedge clk);
        check("vector_ignores_boundary", {29'h0, nestLevel}, 1);
        check("vector_sb_empty", sbQ.size(), 0);

        // reti and a pending interrupt on one boundary: restore first, vector next.
        expectLoad(16'h1234, 1'b0);
        boundary(1'b1, 1'b1, 16'h0080, 16'h2000);
        nextCycle();
        @(negedge clk);
        check("prio_restore_nest", {29'h0, nestLevel}, 0);
        expectLoad(16'h0080, 1'b1);
        boundary(1'b0, 1'b1, 16'h0080, 16'h3000);
        intPending = 1'b0;
        nextCycle();
        @(negedge clk);
        check("prio_vector_nest", {29'h0, nestLevel}, 1);
        expectLoad(16'h3000, 1'b0);
        boundary(1'b1, 1'b0, 16'h0000, 16'h3100);
        nextCycle();
        @(negedge clk);
        check("prio_exit_nest", {29'h0, nestLevel}, 0);
        check("prio_sb_empty", sbQ.size(), 0);

        // reti with an empty stack: no load, sticky error.
        boundary(1'b1, 1'b0, 16'h0000, 16'h4000);
        nextCycle();
        @(negedge clk);
        check("underflow_retiErr", {31'h0, retiErr}, 1);
        check("underflow_nest", {29'h0, nestLevel}, 0);
        repeat (3) nextCycle();
        @(negedge clk);
        check("retiErr_sticky", {31'h0, retiErr}, 1);
        check("underflow_sb_empty", sbQ.size(), 0);

        // Fill the return stack, confirm one more interrupt is refused, then unwind.
        for (int i = 0; i < depth; i++) begin
            savedPc[i] = 16'(16'h0100 * (i + 1));
            expectLoad(16'(16'h0500 + 16'h0010 * i), 1'b1);
            boundary(1'b0, 1'b1, 16'(16'h0500 + 16'h0010 * i), savedPc[i]);
            intPending = 1'b0;
            nextCycle();
            @(negedge clk);
        end
        check("full_nest", {29'h0, nestLevel}, depth);
        check("full_intDisable", {31'h0, intDisable}, 1);
        boundary(1'b0, 1'b1, 16'h0900, 16'h0600);
        nextCycle();
        @(negedge clk);
        check("full_refused_nest", {29'h0, nestLevel}, depth);
        check("full_refused_sb", sbQ.size(), 0);
        intPending = 1'b0;
        for (int i = depth - 1; i >= 0; i--) begin
            expectLoad(savedPc[i], 1'b0);
            boundary(1'b1, 1'b0, 16'h0000, 16'h0700);
            nextCycle();
            @(negedge clk);
        end
        check("unwind_nest", {29'h0, nestLevel}, 0);
        check("unwind_intDisable", {31'h0, intDisable}, 0);
        check("unwind_sb_empty", sbQ.size(), 0);

        // Reset in the VECTOR cycle: no pendClr; the interrupt is taken again after release.
        pcBefore = pendClrSeen;
        boundary(1'b0, 1'b1, 16'h00C0, 16'h0777);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pcLoad", {31'h0, pcLoad}, 0);
        check("midrst_pendClr", {31'h0, pendClr}, 0);
        check("midrst_stall", {31'h0, stall}, 0);
        check("midrst_pcOut", {16'h0, pcOut}, 0);
        check("midrst_nest", {29'h0, nestLevel}, 0);
        check("midrst_intDisable", {31'h0, intDisable}, 1);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        @(negedge clk);
        check("midrst_retiErr_cleared", {31'h0, retiErr}, 0);
        check("midrst_intDisable_rel", {31'h0, intDisable}, 0);
        expectLoad(16'h00C0, 1'b1);
        boundary(1'b0, 1'b1, 16'h00C0, 16'h0888);
        intPending = 1'b0;
        nextCycle();
        @(negedge clk);
        check("midrst_pendClr_once", pendClrSeen - pcBefore, 1);
        check("midrst_retaken_nest", {29'h0, nestLevel}, 1);
        expectLoad(16'h0888, 1'b0);
        boundary(1'b1, 1'b0, 16'h0000, 16'h0999);
        nextCycle();
        @(negedge clk);
        check("final_nest", {29'h0, nestLevel}, 0);
        check("final_sb_empty", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
